// File: rtl/retire_trace_buffer.sv
// Retire-trace buffer: checks PC continuity, keeps retire/trap/cycle counters,
// queues retired-instruction records in a FWFT FIFO and tracks halt/drain completion.
module retire_trace_buffer #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_retire_valid,
  input  logic [31:0]              i_retire_inst,
  input  logic                     i_retire_trap,
  input  logic                     i_retire_halt,
  input  logic [4:0]               i_retire_rd_waddr,
  input  logic [31:0]              i_retire_rd_wdata,
  input  logic [31:0]              i_retire_pc,
  input  logic [31:0]              i_retire_next_pc,
  output logic                     o_trace_valid,
  input  logic                     i_trace_ready,
  output logic [31:0]              o_trace_pc,
  output logic [31:0]              o_trace_inst,
  output logic [31:0]              o_trace_next_pc,
  output logic [4:0]               o_trace_rd_waddr,
  output logic [31:0]              o_trace_rd_wdata,
  output logic [2:0]               o_trace_flags,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_pc_mismatch,
  output logic [31:0]              o_instret,
  output logic [31:0]              o_traps,
  output logic [31:0]              o_cycles,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          r_state;
  logic            r_done;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_exp_pc;
  logic            r_overflow;
  logic            r_pc_mismatch;
  logic [31:0]     r_instret;
  logic [31:0]     r_traps;
  logic [31:0]     r_cycles;

  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_inst  [DEPTH];
  logic [31:0]     r_mem_npc   [DEPTH];
  logic [4:0]      r_mem_rd    [DEPTH];
  logic [31:0]     r_mem_wdata [DEPTH];
  logic [2:0]      r_mem_flags [DEPTH];

  logic            w_accept;
  logic            w_pc_err;
  logic            w_full;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;

  assign w_accept = (r_state == ST_RUN) && i_retire_valid;
  assign w_pc_err = (i_retire_pc != r_exp_pc);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && i_trace_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push   = w_accept && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= i_retire_pc;
      r_mem_inst[r_wr_ptr]  <= i_retire_inst;
      r_mem_npc[r_wr_ptr]   <= i_retire_next_pc;
      r_mem_rd[r_wr_ptr]    <= i_retire_rd_waddr;
      r_mem_wdata[r_wr_ptr] <= i_retire_rd_wdata;
      r_mem_flags[r_wr_ptr] <= {w_pc_err, i_retire_halt, i_retire_trap};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_exp_pc      <= RESET_ADDR;
      r_overflow    <= 1'b0;
      r_pc_mismatch <= 1'b0;
      r_instret     <= '0;
      r_traps       <= '0;
      r_cycles      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      // Dropped records still advance the PC check and counters.
      if (w_accept) begin
        r_exp_pc  <= i_retire_next_pc;
        r_instret <= r_instret + 32'd1;
        if (i_retire_trap) r_traps <= r_traps + 32'd1;
        if (w_pc_err) r_pc_mismatch <= 1'b1;
        if (!w_push) r_overflow <= 1'b1;
      end
      if (r_state == ST_RUN) r_cycles <= r_cycles + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:   if (w_accept && i_retire_halt) r_state <= ST_DRAIN;
        ST_DRAIN: if (!w_valid) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                  end
        default:  r_state <= ST_DONE;
      endcase
    end
  end

  // Head fields are forced to zero while empty so reset clears them without a clock.
  assign o_trace_valid    = w_valid;
  assign o_trace_pc       = w_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign o_trace_inst     = w_valid ? r_mem_inst[r_rd_ptr]  : '0;
  assign o_trace_next_pc  = w_valid ? r_mem_npc[r_rd_ptr]   : '0;
  assign o_trace_rd_waddr = w_valid ? r_mem_rd[r_rd_ptr]    : '0;
  assign o_trace_rd_wdata = w_valid ? r_mem_wdata[r_rd_ptr] : '0;
  assign o_trace_flags    = w_valid ? r_mem_flags[r_rd_ptr] : '0;
  assign o_count          = r_count;
  assign o_overflow       = r_overflow;
  assign o_pc_mismatch    = r_pc_mismatch;
  assign o_instret        = r_instret;
  assign o_traps          = r_traps;
  assign o_cycles         = r_cycles;
  assign o_done           = r_done;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: stimulus queues expected records,
// a negedge monitor pops and compares each record the sink accepts.
module tb_retire_trace_buffer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [2:0]  flags;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_inst = '0;
  logic        retire_trap = 1'b0;
  logic        retire_halt = 1'b0;
  logic [4:0]  retire_rd_waddr = '0;
  logic [31:0] retire_rd_wdata = '0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_next_pc = '0;
  logic        trace_ready = 1'b0;
  logic        o_trace_valid;
  logic [31:0] o_trace_pc, o_trace_inst, o_trace_next_pc, o_trace_rd_wdata;
  logic [4:0]  o_trace_rd_waddr;
  logic [2:0]  o_trace_flags;
  logic [3:0]  o_count;
  logic        o_overflow, o_pc_mismatch, o_done;
  logic [31:0] o_instret, o_traps, o_cycles;

  int   n_checks = 0;
  int   n_fail = 0;
  rec_t exp_q[$];

  retire_trace_buffer #(.DEPTH(8), .RESET_ADDR(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_retire_valid(retire_valid), .i_retire_inst(retire_inst),
    .i_retire_trap(retire_trap), .i_retire_halt(retire_halt),
    .i_retire_rd_waddr(retire_rd_waddr), .i_retire_rd_wdata(retire_rd_wdata),
    .i_retire_pc(retire_pc), .i_retire_next_pc(retire_next_pc),
    .o_trace_valid(o_trace_valid), .i_trace_ready(trace_ready),
    .o_trace_pc(o_trace_pc), .o_trace_inst(o_trace_inst),
    .o_trace_next_pc(o_trace_next_pc), .o_trace_rd_waddr(o_trace_rd_waddr),
    .o_trace_rd_wdata(o_trace_rd_wdata), .o_trace_flags(o_trace_flags),
    .o_count(o_count), .o_overflow(o_overflow), .o_pc_mismatch(o_pc_mismatch),
    .o_instret(o_instret), .o_traps(o_traps), .o_cycles(o_cycles), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && o_trace_valid && trace_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record got pc=%h required no record", o_trace_pc);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (o_trace_pc !== e.pc || o_trace_inst !== e.inst || o_trace_next_pc !== e.npc ||
            o_trace_rd_waddr !== e.rd || o_trace_rd_wdata !== e.wdata || o_trace_flags !== e.flags) begin
          n_fail++;
          $display("FAIL trace_record got pc=%h inst=%h npc=%h rd=%0d wd=%h fl=%b required pc=%h inst=%h npc=%h rd=%0d wd=%h fl=%b",
                   o_trace_pc, o_trace_inst, o_trace_next_pc, o_trace_rd_waddr, o_trace_rd_wdata, o_trace_flags,
                   e.pc, e.inst, e.npc, e.rd, e.wdata, e.flags);
        end else begin
          $display("trace pc=%h npc=%h flags=%b ok", o_trace_pc, o_trace_next_pc, o_trace_flags);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] npc, input logic trap,
                        input logic halt, input logic [2:0] eflags, input bit enq);
    rec_t r;
    r.pc    = pc;
    r.inst  = 32'h0000_0013 | {pc[11:0], 20'h0};
    r.npc   = npc;
    r.rd    = pc[6:2];
    r.wdata = pc ^ 32'hA5A5_0000;
    r.flags = eflags;
    retire_valid    = 1'b1;
    retire_pc       = r.pc;
    retire_inst     = r.inst;
    retire_next_pc  = r.npc;
    retire_rd_waddr = r.rd;
    retire_rd_wdata = r.wdata;
    retire_trap     = trap;
    retire_halt     = halt;
    if (enq) exp_q.push_back(r);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    retire_trap  = 1'b0;
    retire_halt  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_count != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL %s_timeout got %0d queued required 0", name, exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] c0;
    int k;
    #1;
    chk("rst_valid", 32'(o_trace_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_instret", o_instret, 32'd0);
    chk("rst_trace_pc", o_trace_pc, 32'd0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // In-order delivery of a continuous stream.
    trace_ready = 1'b1;
    retire(32'h0, 32'h4, 1'b0, 1'b0, 3'b000, 1'b1);
    retire(32'h4, 32'h8, 1'b0, 1'b0, 3'b000, 1'b1);
    wait_drain("t1");
    chk("t1_instret", o_instret, 32'd2);
    chk("t1_pc_mismatch", 32'(o_pc_mismatch), 32'd0);

    // One discontinuity flagged, no cascade.
    retire(32'h8,  32'h100, 1'b0, 1'b0, 3'b000, 1'b1);
    retire(32'hC,  32'h10,  1'b0, 1'b0, 3'b100, 1'b1);
    retire(32'h10, 32'h14,  1'b0, 1'b0, 3'b000, 1'b1);
    wait_drain("t2");
    chk("t2_pc_mismatch", 32'(o_pc_mismatch), 32'd1);

    // Fill, push-while-full-with-pop, then overflow drops.
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      retire(32'h14 + 32'(4*i), 32'h18 + 32'(4*i), 1'b0, 1'b0, 3'b000, 1'b1);
    chk("t3_count_full", 32'(o_count), 32'd8);
    chk("t3_no_overflow", 32'(o_overflow), 32'd0);
    trace_ready = 1'b1;
    retire(32'h34, 32'h38, 1'b0, 1'b0, 3'b000, 1'b1);
    trace_ready = 1'b0;
    chk("t3_count_pushpop", 32'(o_count), 32'd8);
    chk("t3_overflow_pushpop", 32'(o_overflow), 32'd0);
    retire(32'h38, 32'h3C, 1'b0, 1'b0, 3'b000, 1'b0);
    retire(32'h3C, 32'h40, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("t3_count_drop", 32'(o_count), 32'd8);
    chk("t3_overflow", 32'(o_overflow), 32'd1);
    chk("t3_instret", o_instret, 32'd16);
    trace_ready = 1'b1;
    wait_drain("t3");

    // Halt with three records queued; later retirements ignored.
    trace_ready = 1'b0;
    retire(32'h40, 32'h44, 1'b0, 1'b0, 3'b000, 1'b1);
    retire(32'h44, 32'h48, 1'b1, 1'b0, 3'b001, 1'b1);
    retire(32'h48, 32'h4C, 1'b0, 1'b1, 3'b010, 1'b1);
    retire(32'h4C, 32'h50, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("t4_count", 32'(o_count), 32'd3);
    chk("t4_instret", o_instret, 32'd19);
    chk("t4_traps", o_traps, 32'd1);
    chk("t4_done_early", 32'(o_done), 32'd0);
    c0 = o_cycles;
    k = 0;
    while (o_count != 0 && k < 50) begin
      trace_ready = ~trace_ready;
      @(posedge clk); #1;
      k++;
    end
    trace_ready = 1'b0;
    chk("t4_drain_bound", 32'(k < 50), 32'd1);
    chk("t4_done_at_empty", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    chk("t4_done", 32'(o_done), 32'd1);
    chk("t4_cycles_frozen", o_cycles, c0);
    retire(32'h50, 32'h54, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("t4_instret_done", o_instret, 32'd19);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a drain.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    retire(32'h0, 32'h4, 1'b0, 1'b0, 3'b000, 1'b1);
    retire(32'h4, 32'h8, 1'b0, 1'b1, 3'b010, 1'b1);
    chk("t5_count_pre", 32'(o_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_valid", 32'(o_trace_valid), 32'd0);
    chk("t5_count", 32'(o_count), 32'd0);
    chk("t5_instret", o_instret, 32'd0);
    chk("t5_cycles", o_cycles, 32'd0);
    chk("t5_trace_pc", o_trace_pc, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    trace_ready = 1'b1;
    retire(32'h0, 32'h4, 1'b0, 1'b0, 3'b000, 1'b1);
    wait_drain("t5");
    chk("t5_run_instret", o_instret, 32'd1);
    chk("t5_pc_mismatch", 32'(o_pc_mismatch), 32'd0);
    chk("t5_done", 32'(o_done), 32'd0);
    chk("t5_cycles_run", 32'(o_cycles != 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
